dispatch_sched: RTL and testbench

- In-order dispatch scheduler between the decoder and the reservation stations (RS) of the ALU, LSU and MUL/DIV units.
- Buffers decoded instructions in a small FIFO and tracks free RS entries per unit with credit counters.
- Dispatches the FIFO head to its unit when that unit has a credit, and tags each dispatch with a wrapping sequence number.
- Branch and jump instructions go to the ALU.

---
 rtl/dispatch_sched.sv | 142 ++++++++++++++
 tb/tb_dispatch_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_sched.sv
// dispatch_sched: in-order instruction FIFO feeding ALU/LSU/MD
// reservation stations under per-unit credit flow control.
module dispatch_sched #(
  parameter int QDEPTH   = 4,
  parameter int ALU_CRED = 4,
  parameter int LSU_CRED = 4,
  parameter int MD_CRED  = 2,
  parameter int TAG_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_i,
  input  logic [3:0]       class_i,
  input  logic             alu_rel_i,
  input  logic             lsu_rel_i,
  input  logic             md_rel_i,
  output logic             disp_valid_o,
  output logic [2:0]       disp_unit_o,
  output logic [31:0]      disp_inst_o,
  output logic [TAG_W-1:0] disp_tag_o,
  output logic             illegal_o,
  output logic             cred_err_o
);

  localparam int AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNW  = $clog2(QDEPTH + 1);
  localparam int CM1  = (ALU_CRED > LSU_CRED) ? ALU_CRED : LSU_CRED;
  localparam int CMAX = (CM1 > MD_CRED) ? CM1 : MD_CRED;
  localparam int CRW  = $clog2(CMAX + 1);

  localparam logic [CRW-1:0] ALU_MAX = CRW'(ALU_CRED);
  localparam logic [CRW-1:0] LSU_MAX = CRW'(LSU_CRED);
  localparam logic [CRW-1:0] MD_MAX  = CRW'(MD_CRED);
  localparam logic [CNW-1:0] QFULL   = CNW'(QDEPTH);

  logic [31:0]      inst_q [QDEPTH];
  logic [3:0]       cls_q  [QDEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CNW-1:0]   count;
  logic [CRW-1:0]   alu_cred, lsu_cred, md_cred;
  logic [TAG_W-1:0] tag;

  logic [3:0] head_cls;
  logic [2:0] sel_unit;
  logic       illegal_head, has_cred;
  logic       active, disp, pop_ill, pop, push;
  logic       err_any;

  function automatic logic [CRW-1:0] cred_upd(
    input logic [CRW-1:0] c,
    input logic [CRW-1:0] mx,
    input logic           dec,
    input logic           rel
  );
    logic [CRW-1:0] r;
    r = c;
    if (dec && !rel)
      r = c - CRW'(1);
    else if (rel && !dec && c != mx)
      r = c + CRW'(1);
    return r;
  endfunction

  assign in_ready_o = (count < QFULL);
  assign head_cls   = cls_q[rptr];

  // Overlapping class bits resolve muldiv > lsu > alu/br.
  always_comb begin
    sel_unit     = 3'b000;
    illegal_head = 1'b0;
    priority case (1'b1)
      head_cls[1]:               sel_unit = 3'b001;
      head_cls[2]:               sel_unit = 3'b010;
      head_cls[3], head_cls[0]:  sel_unit = 3'b100;
      default:                   illegal_head = 1'b1;
    endcase
  end

  assign has_cred = |(sel_unit & {alu_cred != '0,
                                  lsu_cred != '0,
                                  md_cred  != '0});
  assign active  = (count != '0) && !flush_i;
  assign pop_ill = active && illegal_head;
  assign disp    = active && !illegal_head && has_cred;
  assign pop     = pop_ill || disp;
  assign push    = in_valid_i && in_ready_o && !flush_i;

  assign err_any = (alu_rel_i && !(disp && sel_unit[2]) && alu_cred == ALU_MAX)
                || (lsu_rel_i && !(disp && sel_unit[1]) && lsu_cred == LSU_MAX)
                || (md_rel_i  && !(disp && sel_unit[0]) && md_cred  == MD_MAX);

  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_q[wptr] <= inst_i;
      cls_q[wptr]  <= class_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      tag          <= '0;
      alu_cred     <= ALU_MAX;
      lsu_cred     <= LSU_MAX;
      md_cred      <= MD_MAX;
      disp_valid_o <= 1'b0;
      disp_unit_o  <= 3'b000;
      disp_inst_o  <= '0;
      disp_tag_o   <= '0;
      illegal_o    <= 1'b0;
      cred_err_o   <= 1'b0;
    end else begin
      if (flush_i) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        wptr  <= wptr + AW'(push);
        rptr  <= rptr + AW'(pop);
        count <= count + CNW'(push) - CNW'(pop);
      end
      alu_cred     <= cred_upd(alu_cred, ALU_MAX, disp && sel_unit[2], alu_rel_i);
      lsu_cred     <= cred_upd(lsu_cred, LSU_MAX, disp && sel_unit[1], lsu_rel_i);
      md_cred      <= cred_upd(md_cred,  MD_MAX,  disp && sel_unit[0], md_rel_i);
      cred_err_o   <= cred_err_o || err_any;
      disp_valid_o <= disp;
      illegal_o    <= pop_ill;
      if (disp) begin
        disp_unit_o <= sel_unit;
        disp_inst_o <= inst_q[rptr];
        disp_tag_o  <= tag;
        tag         <= tag + TAG_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dispatch_sched.sv
// tb_dispatch_sched: directed scenarios for the dispatch scheduler
// with a negedge monitor recording every dispatch.
module tb_dispatch_sched;

  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] MUL  = 32'h02208033;
  localparam logic [31:0] LW   = 32'h0000a103;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] ILL  = 32'hffffffff;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] inst_i = '0;
  logic [3:0]  class_i = '0;
  logic        alu_rel_i = 1'b0;
  logic        lsu_rel_i = 1'b0;
  logic        md_rel_i = 1'b0;
  logic        disp_valid_o;
  logic [2:0]  disp_unit_o;
  logic [31:0] disp_inst_o;
  logic [3:0]  disp_tag_o;
  logic        illegal_o;
  logic        cred_err_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nd = 0;
  int ilc = 0;
  int ilcyc = 0;
  logic [2:0]  du [64];
  logic [3:0]  dt [64];
  logic [31:0] di [64];
  int          dc [64];

  dispatch_sched dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .class_i(class_i),
    .alu_rel_i(alu_rel_i), .lsu_rel_i(lsu_rel_i), .md_rel_i(md_rel_i),
    .disp_valid_o(disp_valid_o), .disp_unit_o(disp_unit_o),
    .disp_inst_o(disp_inst_o), .disp_tag_o(disp_tag_o),
    .illegal_o(illegal_o), .cred_err_o(cred_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (disp_valid_o === 1'b1 && nd < 64) begin
      du[nd] = disp_unit_o;
      dt[nd] = disp_tag_o;
      di[nd] = disp_inst_o;
      dc[nd] = cyc;
      nd = nd + 1;
    end
    if (illegal_o === 1'b1) begin
      ilc = ilc + 1;
      ilcyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    flush_i = 1'b0; in_valid_i = 1'b0;
    alu_rel_i = 1'b0; lsu_rel_i = 1'b0; md_rel_i = 1'b0;
    nd = 0; ilc = 0; ilcyc = 0;
    for (int k = 0; k < 64; k++) begin
      du[k] = 'x; dt[k] = 'x; di[k] = 'x; dc[k] = -1;
    end
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic push(input logic [31:0] i, input logic [3:0] c);
    int n;
    n = 0;
    while (in_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL push_wait got ready=%b want 1", in_ready_o);
    end
    in_valid_i = 1'b1; inst_i = i; class_i = c;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", disp_valid_o); end
    checks++; if (disp_unit_o !== 3'b000) begin errors++; $display("FAIL rst_unit got %b want 000", disp_unit_o); end
    checks++; if (disp_inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got %h want 0", disp_inst_o); end
    checks++; if (disp_tag_o !== 4'h0) begin errors++; $display("FAIL rst_tag got %0d want 0", disp_tag_o); end
    checks++; if (illegal_o !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b want 0", illegal_o); end
    checks++; if (cred_err_o !== 1'b0) begin errors++; $display("FAIL rst_cerr got %b want 0", cred_err_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready_o); end
  endtask

  task automatic test_alu();
    int p, r;
    do_reset();
    push(ADDI, 4'b1000);
    p = cyc;
    repeat (3) tick();
    checks++; if (nd !== 1) begin errors++; $display("FAIL alu_n got %0d want 1", nd); end
    checks++; if (dc[0] !== p + 1) begin errors++; $display("FAIL alu_lat got %0d want %0d", dc[0], p + 1); end
    checks++; if (du[0] !== 3'b100) begin errors++; $display("FAIL alu_unit got %b want 100", du[0]); end
    checks++; if (dt[0] !== 4'd0) begin errors++; $display("FAIL alu_tag got %0d want 0", dt[0]); end
    checks++; if (di[0] !== ADDI) begin errors++; $display("FAIL alu_inst got %h want %h", di[0], ADDI); end
    for (int k = 1; k <= 4; k++) push(ADDI + k, 4'b1000);
    repeat (4) tick();
    checks++; if (nd !== 4) begin errors++; $display("FAIL alu_cred3 got %0d want 4", nd); end
    checks++; if (dt[3] !== 4'd3) begin errors++; $display("FAIL alu_tag3 got %0d want 3", dt[3]); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL alu_ready got %b want 1", in_ready_o); end
    alu_rel_i = 1'b1; tick(); alu_rel_i = 1'b0;
    r = cyc;
    repeat (3) tick();
    checks++; if (nd !== 5) begin errors++; $display("FAIL alu_rel_n got %0d want 5", nd); end
    checks++; if (dc[4] !== r + 1) begin errors++; $display("FAIL alu_rel_lat got %0d want %0d", dc[4], r + 1); end
    checks++; if (dt[4] !== 4'd4) begin errors++; $display("FAIL alu_rel_tag got %0d want 4", dt[4]); end
    checks++; if (di[4] !== ADDI + 4) begin errors++; $display("FAIL alu_rel_inst got %h want %h", di[4], ADDI + 4); end
  endtask

  task automatic test_md_stall();
    int r;
    do_reset();
    for (int k = 0; k < 3; k++) push(MUL + k, 4'b0010);
    repeat (4) tick();
    checks++; if (nd !== 2) begin errors++; $display("FAIL md_n got %0d want 2", nd); end
    checks++; if (dt[1] !== 4'd1) begin errors++; $display("FAIL md_tag1 got %0d want 1", dt[1]); end
    checks++; if (du[1] !== 3'b001) begin errors++; $display("FAIL md_unit got %b want 001", du[1]); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL md_ready got %b want 1", in_ready_o); end
    md_rel_i = 1'b1; tick(); md_rel_i = 1'b0;
    r = cyc;
    repeat (3) tick();
    checks++; if (nd !== 3) begin errors++; $display("FAIL md_rel_n got %0d want 3", nd); end
    checks++; if (dc[2] !== r + 1) begin errors++; $display("FAIL md_rel_lat got %0d want %0d", dc[2], r + 1); end
    checks++; if (dt[2] !== 4'd2) begin errors++; $display("FAIL md_rel_tag got %0d want 2", dt[2]); end
    checks++; if (di[2] !== MUL + 2) begin errors++; $display("FAIL md_rel_inst got %h want %h", di[2], MUL + 2); end
  endtask

  task automatic test_hol();
    int r;
    do_reset();
    push(MUL, 4'b0010); push(MUL + 1, 4'b0010);
    repeat (3) tick();
    push(MUL + 2, 4'b0010);
    for (int k = 0; k < 3; k++) push(ADDI + k, 4'b1000);
    repeat (3) tick();
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL hol_full got %b want 0", in_ready_o); end
    checks++; if (nd !== 2) begin errors++; $display("FAIL hol_block got %0d want 2", nd); end
    md_rel_i = 1'b1; tick(); md_rel_i = 1'b0;
    r = cyc;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL hol_nobypass got %b want 0", in_ready_o); end
    repeat (5) tick();
    checks++; if (nd !== 6) begin errors++; $display("FAIL hol_n got %0d want 6", nd); end
    checks++; if (du[2] !== 3'b001 || dc[2] !== r + 1) begin errors++; $display("FAIL hol_mul got %b@%0d want 001@%0d", du[2], dc[2], r + 1); end
    checks++; if (du[3] !== 3'b100 || dc[3] !== r + 2) begin errors++; $display("FAIL hol_a0 got %b@%0d want 100@%0d", du[3], dc[3], r + 2); end
    checks++; if (dc[5] !== r + 4 || dt[5] !== 4'd5) begin errors++; $display("FAIL hol_a2 got t%0d@%0d want t5@%0d", dt[5], dc[5], r + 4); end
    checks++; if (di[5] !== ADDI + 2) begin errors++; $display("FAIL hol_inst got %h want %h", di[5], ADDI + 2); end
    push(ADDI + 3, 4'b1000);
    repeat (3) tick();
    checks++; if (nd !== 7 || dt[6] !== 4'd6) begin errors++; $display("FAIL hol_last got n%0d t%0d want n7 t6", nd, dt[6]); end
  endtask

  task automatic test_illegal();
    int p;
    do_reset();
    push(ILL, 4'b0000); push(BEQ, 4'b1000); push(LW, 4'b0100);
    p = cyc;
    repeat (3) tick();
    checks++; if (ilc !== 1) begin errors++; $display("FAIL ill_cnt got %0d want 1", ilc); end
    checks++; if (ilcyc !== p - 1) begin errors++; $display("FAIL ill_cyc got %0d want %0d", ilcyc, p - 1); end
    checks++; if (nd !== 2) begin errors++; $display("FAIL ill_n got %0d want 2", nd); end
    checks++; if (du[0] !== 3'b100 || dt[0] !== 4'd0) begin errors++; $display("FAIL ill_beq got %b t%0d want 100 t0", du[0], dt[0]); end
    checks++; if (dc[0] !== p) begin errors++; $display("FAIL ill_beq_cyc got %0d want %0d", dc[0], p); end
    checks++; if (du[1] !== 3'b010 || dt[1] !== 4'd1) begin errors++; $display("FAIL ill_lw got %b t%0d want 010 t1", du[1], dt[1]); end
    push(MUL, 4'b1110); push(LW, 4'b1101); push(BEQ, 4'b0001);
    repeat (3) tick();
    checks++; if (nd !== 5) begin errors++; $display("FAIL pri_n got %0d want 5", nd); end
    checks++; if (du[2] !== 3'b001) begin errors++; $display("FAIL pri_md got %b want 001", du[2]); end
    checks++; if (du[3] !== 3'b010) begin errors++; $display("FAIL pri_lsu got %b want 010", du[3]); end
    checks++; if (du[4] !== 3'b100 || dt[4] !== 4'd4) begin errors++; $display("FAIL pri_br got %b t%0d want 100 t4", du[4], dt[4]); end
  endtask

  task automatic test_credit();
    int p;
    do_reset();
    push(LW, 4'b0100);
    repeat (2) tick();
    in_valid_i = 1'b1; inst_i = LW + 1; class_i = 4'b0100;
    tick();
    in_valid_i = 1'b0;
    p = cyc;
    lsu_rel_i = 1'b1; tick(); lsu_rel_i = 1'b0;
    for (int k = 2; k <= 5; k++) push(LW + k, 4'b0100);
    repeat (4) tick();
    checks++; if (dc[1] !== p + 1) begin errors++; $display("FAIL race_cyc got %0d want %0d", dc[1], p + 1); end
    checks++; if (nd !== 5) begin errors++; $display("FAIL race_cred got %0d want 5", nd); end
    checks++; if (cred_err_o !== 1'b0) begin errors++; $display("FAIL race_cerr got %b want 0", cred_err_o); end
    do_reset();
    alu_rel_i = 1'b1; tick(); alu_rel_i = 1'b0;
    checks++; if (cred_err_o !== 1'b1) begin errors++; $display("FAIL sat_cerr got %b want 1", cred_err_o); end
    for (int k = 0; k < 5; k++) push(ADDI + k, 4'b1000);
    repeat (4) tick();
    checks++; if (nd !== 4) begin errors++; $display("FAIL sat_cred got %0d want 4", nd); end
    checks++; if (cred_err_o !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b want 1", cred_err_o); end
    do_reset();
    checks++; if (cred_err_o !== 1'b0) begin errors++; $display("FAIL sat_clr got %b want 0", cred_err_o); end
  endtask

  task automatic test_flush();
    int p;
    do_reset();
    for (int k = 0; k < 5; k++) push(MUL + k, 4'b0010);
    tick();
    flush_i = 1'b1; md_rel_i = 1'b1;
    in_valid_i = 1'b1; inst_i = ADDI + 9; class_i = 4'b1000;
    tick();
    flush_i = 1'b0; md_rel_i = 1'b0; in_valid_i = 1'b0;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL fl_ready got %b want 1", in_ready_o); end
    repeat (3) tick();
    checks++; if (nd !== 2) begin errors++; $display("FAIL fl_empty got %0d want 2", nd); end
    push(ADDI + 7, 4'b1000);
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    repeat (2) tick();
    checks++; if (nd !== 2) begin errors++; $display("FAIL fl_kill got %0d want 2", nd); end
    push(ADDI, 4'b1000);
    p = cyc;
    repeat (3) tick();
    checks++; if (nd !== 3 || dc[2] !== p + 1) begin errors++; $display("FAIL fl_next got n%0d@%0d want n3@%0d", nd, dc[2], p + 1); end
    checks++; if (dt[2] !== 4'd2 || di[2] !== ADDI) begin errors++; $display("FAIL fl_tag got t%0d %h want t2 %h", dt[2], di[2], ADDI); end
    push(MUL + 8, 4'b0010);
    repeat (3) tick();
    checks++; if (nd !== 4 || du[3] !== 3'b001) begin errors++; $display("FAIL fl_rel got n%0d %b want n4 001", nd, du[3]); end
  endtask

  task automatic test_tag_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid_i = 1'b1; inst_i = ADDI + i; class_i = 4'b1000;
      alu_rel_i = (i > 0);
      tick();
    end
    in_valid_i = 1'b0; alu_rel_i = 1'b0;
    repeat (3) tick();
    checks++; if (nd !== 17) begin errors++; $display("FAIL wrap_n got %0d want 17", nd); end
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (dt[i] !== 4'(i)) begin errors++; $display("FAIL wrap_tag%0d got %0d want %0d", i, dt[i], 4'(i)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(ADDI + 5, 4'b1000);
    tick();
    checks++; if (disp_valid_o !== 1'b1) begin errors++; $display("FAIL ar_pre got %b want 1", disp_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (disp_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", disp_valid_o); end
    checks++; if (disp_unit_o !== 3'b000) begin errors++; $display("FAIL ar_unit got %b want 000", disp_unit_o); end
    checks++; if (disp_inst_o !== 32'h0) begin errors++; $display("FAIL ar_inst got %h want 0", disp_inst_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready got %b want 1", in_ready_o); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_md_stall();
    test_hol();
    test_illegal();
    test_credit();
    test_flush();
    test_tag_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
